// File: rtl/capture_reader_pkg.sv
// Shared constants for the capture readback path: FSM encodings, default
// buffer geometry and the depth of the returned-pair FIFO.
package capture_reader_pkg;

  localparam int FIFO_SIZE_DEFAULT  = 1024;
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int PAIR_FIFO_DEPTH    = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/capture_rd_fifo.sv
// Small synchronous FIFO holding {ch1, ch0} sample pairs returned from BRAM.
// Flush has priority over push and pop so an aborted readback leaves it empty.
module capture_rd_fifo
  import capture_reader_pkg::*;
#(
  parameter int WIDTH = 2 * DATA_WIDTH_DEFAULT,
  parameter int DEPTH = PAIR_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Storage needs no reset; the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/capture_reader.sv
// Reads both captured channel buffers back from BRAM after a finished
// measurement and streams them interleaved (ch0[i], ch1[i]) over valid/ready.
module capture_reader
  import capture_reader_pkg::*;
#(
  parameter int FIFO_SIZE       = FIFO_SIZE_DEFAULT,
  parameter int FIFO_SIZE_WIDTH = $clog2(FIFO_SIZE) + 1,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEFAULT,
  parameter int RD_LATENCY      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       finish_op,
  input  logic [FIFO_SIZE_WIDTH-1:0] data_count_ch0,
  input  logic [FIFO_SIZE_WIDTH-1:0] data_count_ch1,
  input  logic                       start_read,
  output logic                       rd_en,
  output logic [FIFO_SIZE_WIDTH-2:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]      rd_data_ch0,
  input  logic [DATA_WIDTH-1:0]      rd_data_ch1,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_ch,
  output logic                       m_last,
  output logic                       m_vld,
  input  logic                       m_rdy,
  output logic                       busy,
  output logic                       read_done,
  output logic                       event_start_read_when_not_ready,
  output logic                       event_count_mismatch,
  output logic                       event_finish_lost
);

  localparam int AW  = FIFO_SIZE_WIDTH - 1;
  localparam int CW  = FIFO_SIZE_WIDTH;
  localparam int PCW = $clog2(PAIR_FIFO_DEPTH) + 1;

  logic [1:0]              state;
  logic [CW-1:0]           n_pairs;
  logic [CW-1:0]           n_new;
  logic [CW-1:0]           out_idx;
  logic                    sel_ch1;
  logic [RD_LATENCY-1:0]   vld_pipe;
  logic [PCW-1:0]          in_flight;
  logic [2*DATA_WIDTH-1:0] fifo_head;
  logic                    fifo_empty;
  logic [PCW-1:0]          fifo_count;
  logic                    abort;
  logic                    start_ok;
  logic                    fire;
  logic                    last_issue;

  always_comb begin
    n_new = (data_count_ch0 < data_count_ch1) ? data_count_ch0 : data_count_ch1;
    if (n_new > CW'(FIFO_SIZE)) n_new = CW'(FIFO_SIZE);
  end

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + PCW'(vld_pipe[i]);
  end

  // A read is only issued when its pair is guaranteed a FIFO slot on return,
  // so back-pressure can never cause a returned pair to be dropped.
  assign busy       = (state == ST_READ) || (state == ST_DRAIN);
  assign abort      = busy && !finish_op;
  assign start_ok   = (state == ST_IDLE) && start_read && finish_op;
  assign rd_en      = (state == ST_READ) && finish_op &&
                      ((in_flight + fifo_count) < PCW'(PAIR_FIFO_DEPTH));
  assign last_issue = ({1'b0, rd_addr} == (n_pairs - CW'(1)));

  assign m_vld  = !fifo_empty;
  assign fire   = m_vld && m_rdy;
  assign m_data = !m_vld ? '0 :
                  sel_ch1 ? fifo_head[2*DATA_WIDTH-1:DATA_WIDTH] : fifo_head[DATA_WIDTH-1:0];
  assign m_ch   = m_vld && sel_ch1;
  assign m_last = m_vld && sel_ch1 && (out_idx == (n_pairs - CW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                           <= ST_IDLE;
      n_pairs                         <= '0;
      rd_addr                         <= '0;
      out_idx                         <= '0;
      sel_ch1                         <= 1'b0;
      read_done                       <= 1'b0;
      event_count_mismatch            <= 1'b0;
      event_start_read_when_not_ready <= 1'b0;
      event_finish_lost               <= 1'b0;
    end else begin
      read_done                       <= 1'b0;
      event_count_mismatch            <= 1'b0;
      event_finish_lost               <= 1'b0;
      event_start_read_when_not_ready <= start_read && !start_ok;
      if (abort) begin
        event_finish_lost <= 1'b1;
        state             <= ST_IDLE;
        rd_addr           <= '0;
        out_idx           <= '0;
        sel_ch1           <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_ok) begin
              n_pairs              <= n_new;
              event_count_mismatch <= (data_count_ch0 != data_count_ch1);
              rd_addr              <= '0;
              out_idx              <= '0;
              sel_ch1              <= 1'b0;
              if (n_new == '0) read_done <= 1'b1;
              else             state     <= ST_READ;
            end
          end
          ST_READ: begin
            if (rd_en) begin
              if (last_issue) begin
                rd_addr <= '0;
                state   <= ST_DRAIN;
              end else begin
                rd_addr <= rd_addr + AW'(1);
              end
            end
          end
          default: ;
        endcase
        // Each pair is shown as ch0 then ch1 and popped after the ch1 word.
        if (fire) begin
          sel_ch1 <= !sel_ch1;
          if (sel_ch1) begin
            out_idx <= out_idx + CW'(1);
            if (m_last) begin
              read_done <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (abort) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  capture_rd_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (PAIR_FIFO_DEPTH)
  ) u_pair_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_pipe[RD_LATENCY-1]),
    .push_data ({rd_data_ch1, rd_data_ch0}),
    .pop       (fire && sel_ch1),
    .flush     (abort),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_capture_reader.sv
// Randomized bench for capture_reader: a BRAM model feeds the DUT and a
// queue-based model of the expected word stream and pulses checks every cycle.
module tb_capture_reader;

  localparam int FIFO_SIZE  = 1024;
  localparam int CW         = 11;
  localparam int DW         = 32;
  localparam int RD_LATENCY = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          finish_op;
  logic [CW-1:0] data_count_ch0;
  logic [CW-1:0] data_count_ch1;
  logic          start_read;
  logic          rd_en;
  logic [CW-2:0] rd_addr;
  logic [DW-1:0] rd_data_ch0;
  logic [DW-1:0] rd_data_ch1;
  logic [DW-1:0] m_data;
  logic          m_ch;
  logic          m_last;
  logic          m_vld;
  logic          m_rdy;
  logic          busy;
  logic          read_done;
  logic          event_start_read_when_not_ready;
  logic          event_count_mismatch;
  logic          event_finish_lost;

  capture_reader #(
    .FIFO_SIZE       (FIFO_SIZE),
    .FIFO_SIZE_WIDTH (CW),
    .DATA_WIDTH      (DW),
    .RD_LATENCY      (RD_LATENCY)
  ) dut (
    .clk                             (clk),
    .rst                             (rst),
    .finish_op                       (finish_op),
    .data_count_ch0                  (data_count_ch0),
    .data_count_ch1                  (data_count_ch1),
    .start_read                      (start_read),
    .rd_en                           (rd_en),
    .rd_addr                         (rd_addr),
    .rd_data_ch0                     (rd_data_ch0),
    .rd_data_ch1                     (rd_data_ch1),
    .m_data                          (m_data),
    .m_ch                            (m_ch),
    .m_last                          (m_last),
    .m_vld                           (m_vld),
    .m_rdy                           (m_rdy),
    .busy                            (busy),
    .read_done                       (read_done),
    .event_start_read_when_not_ready (event_start_read_when_not_ready),
    .event_count_mismatch            (event_count_mismatch),
    .event_finish_lost               (event_finish_lost)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_pct = 100;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Channel buffers, read with a fixed RD_LATENCY like the real BRAM.
  logic [DW-1:0]   mem0 [FIFO_SIZE];
  logic [DW-1:0]   mem1 [FIFO_SIZE];
  logic [2*DW-1:0] bram_pipe [RD_LATENCY];

  always @(posedge clk) begin
    if (rd_en) bram_pipe[0] <= {mem1[rd_addr], mem0[rd_addr]};
    for (int k = 1; k < RD_LATENCY; k++) bram_pipe[k] <= bram_pipe[k-1];
  end
  assign rd_data_ch0 = bram_pipe[RD_LATENCY-1][DW-1:0];
  assign rd_data_ch1 = bram_pipe[RD_LATENCY-1][2*DW-1:DW];

  initial begin
    m_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1 m_rdy = ($urandom_range(99) < rdy_pct);
    end
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ch;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] acc_q[$];
  word_t         w;
  bit            model_busy = 0;
  bit            busy_now;
  bit            exp_done = 0, exp_mm = 0, exp_nr = 0, exp_fl = 0;
  bit            saw_done = 0, saw_mm = 0, saw_nr = 0, saw_fl = 0;
  int            model_n = 0;
  int            exp_addr = 0;
  int            issued = 0;
  int            pairs_popped = 0;
  int            t0 = 0;
  int            first_vld = -1;
  int            last_acc = -1;

  // Model: a readback is just the list ch0[0], ch1[0], ... ch1[N-1], and each
  // pulse is predicted one cycle ahead from what happened this cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_busy = 0;
      exp_done = 0; exp_mm = 0; exp_nr = 0; exp_fl = 0;
    end else begin
      busy_now = model_busy;
      check_output("read_done", 64'(read_done), 64'(exp_done));
      check_output("ev_count_mismatch", 64'(event_count_mismatch), 64'(exp_mm));
      check_output("ev_not_ready", 64'(event_start_read_when_not_ready), 64'(exp_nr));
      check_output("ev_finish_lost", 64'(event_finish_lost), 64'(exp_fl));
      check_output("busy", 64'(busy), 64'(busy_now));
      saw_done |= read_done; saw_mm |= event_count_mismatch;
      saw_nr |= event_start_read_when_not_ready; saw_fl |= event_finish_lost;
      exp_done = 0; exp_mm = 0; exp_nr = 0; exp_fl = 0;

      if (rd_en) begin
        check_output("rd_en_while_idle", 64'(busy_now), 64'd1);
        if (busy_now) begin
          check_output("rd_addr", 64'(rd_addr), 64'(exp_addr));
          check_output("rd_addr_bound", 64'(int'(rd_addr) < model_n), 64'd1);
          check_output("credit_limit", 64'((issued - pairs_popped) < 4), 64'd1);
          exp_addr++;
          issued++;
        end
      end

      if (m_vld) begin
        if (exp_q.size() == 0) begin
          check_output("m_vld_unexpected", 64'(m_vld), 64'd0);
        end else begin
          w = exp_q[0];
          check_output("m_data", 64'(m_data), 64'(w.data));
          check_output("m_ch", 64'(m_ch), 64'(w.ch));
          check_output("m_last", 64'(m_last), 64'(w.last));
          if (first_vld < 0) first_vld = cyc - t0;
          if (m_rdy) begin
            void'(exp_q.pop_front());
            acc_q.push_back(m_data);
            last_acc = cyc - t0;
            if (w.ch) pairs_popped++;
            if (w.last) begin
              model_busy = 0;
              exp_done = 1;
            end
          end
        end
      end

      if (start_read) begin
        if (!busy_now && finish_op) begin
          model_n = (data_count_ch0 < data_count_ch1) ? int'(data_count_ch0) : int'(data_count_ch1);
          if (model_n > FIFO_SIZE) model_n = FIFO_SIZE;
          exp_mm = (data_count_ch0 != data_count_ch1);
          exp_q.delete();
          exp_addr = 0; issued = 0; pairs_popped = 0;
          t0 = cyc; first_vld = -1; last_acc = -1;
          for (int i = 0; i < model_n; i++) begin
            exp_q.push_back('{data: mem0[i], ch: 1'b0, last: 1'b0});
            exp_q.push_back('{data: mem1[i], ch: 1'b1, last: (i == model_n - 1)});
          end
          if (model_n == 0) exp_done = 1;
          else              model_busy = 1;
        end else begin
          exp_nr = 1;
        end
      end

      if (busy_now && !finish_op) begin
        exp_fl = 1;
        exp_done = 0;
        exp_q.delete();
        model_busy = 0;
      end
    end
  end

  task automatic apply_stimulus(input logic [CW-1:0] c0, input logic [CW-1:0] c1);
    @(posedge clk);
    #1;
    data_count_ch0 = c0;
    data_count_ch1 = c1;
    start_read = 1'b1;
    @(posedge clk);
    #1 start_read = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((model_busy || exp_q.size() != 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_output("run_timeout", 64'(k >= budget), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (acc_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_output("word_wait_timeout", 64'(k >= budget), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; finish_op = 1'b0; start_read = 1'b0;
    data_count_ch0 = '0; data_count_ch1 = '0;
    for (int i = 0; i < FIFO_SIZE; i++) begin
      mem0[i] = 32'h100 + i;
      mem1[i] = 32'h200 + i;
    end
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_m_vld", 64'(m_vld), 64'd0);
    check_output("reset_rd_en", 64'(rd_en), 64'd0);
    check_output("reset_rd_addr", 64'(rd_addr), 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_m_data", 64'(m_data), 64'd0);
    #2 rst = 1'b0;

    $display("[TB] basic readback 8/8");
    finish_op = 1'b1; rdy_pct = 100; acc_q.delete(); saw_done = 0;
    apply_stimulus(11'd8, 11'd8);
    wait_idle(200);
    check_output("basic_words", 64'(acc_q.size()), 64'd16);
    if (acc_q.size() == 16) begin
      check_output("basic_first", 64'(acc_q[0]), 64'h100);
      check_output("basic_second", 64'(acc_q[1]), 64'h200);
      check_output("basic_last", 64'(acc_q[15]), 64'h207);
    end
    check_output("basic_first_vld_cycle", 64'(first_vld), 64'd4);
    check_output("basic_last_word_cycle", 64'(last_acc), 64'd19);
    check_output("basic_done_seen", 64'(saw_done), 64'd1);

    $display("[TB] count mismatch 5/3");
    for (int i = 0; i < 8; i++) begin
      mem0[i] = 32'h500 + i;
      mem1[i] = 32'h600 + i;
    end
    acc_q.delete(); saw_mm = 0;
    apply_stimulus(11'd5, 11'd3);
    wait_idle(200);
    check_output("mismatch_words", 64'(acc_q.size()), 64'd6);
    if (acc_q.size() == 6) check_output("mismatch_last", 64'(acc_q[5]), 64'h602);
    check_output("mismatch_seen", 64'(saw_mm), 64'd1);

    $display("[TB] zero count and not ready");
    acc_q.delete(); saw_done = 0;
    apply_stimulus(11'd0, 11'd0);
    wait_idle(50);
    check_output("zero_done_seen", 64'(saw_done), 64'd1);
    check_output("zero_words", 64'(acc_q.size()), 64'd0);
    finish_op = 1'b0; saw_nr = 0;
    apply_stimulus(11'd8, 11'd8);
    repeat (6) @(posedge clk);
    #1;
    check_output("not_ready_seen", 64'(saw_nr), 64'd1);
    check_output("not_ready_busy", 64'(busy), 64'd0);
    finish_op = 1'b1;

    $display("[TB] back-pressure, full buffers");
    for (int i = 0; i < FIFO_SIZE; i++) begin
      mem0[i] = $urandom;
      mem1[i] = $urandom;
    end
    acc_q.delete(); rdy_pct = 30;
    apply_stimulus(11'd1024, 11'd1024);
    wait_idle(15000);
    check_output("bp_words", 64'(acc_q.size()), 64'd2048);
    if (acc_q.size() == 2048) check_output("bp_last", 64'(acc_q[2047]), 64'(mem1[1023]));

    $display("[TB] clamp to buffer size");
    acc_q.delete(); rdy_pct = 90;
    apply_stimulus(11'd2000, 11'd1030);
    wait_idle(5000);
    check_output("clamp_words", 64'(acc_q.size()), 64'd2048);

    $display("[TB] abort after 10 words");
    acc_q.delete(); rdy_pct = 100; saw_fl = 0; saw_done = 0;
    apply_stimulus(11'd16, 11'd16);
    wait_words(10, 200);
    #1 finish_op = 1'b0;
    @(posedge clk);
    #1;
    check_output("abort_m_vld", 64'(m_vld), 64'd0);
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_event", 64'(event_finish_lost), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check_output("abort_no_done", 64'(saw_done), 64'd0);
    finish_op = 1'b1;
    acc_q.delete();
    apply_stimulus(11'd4, 11'd4);
    wait_idle(200);
    check_output("restart_words", 64'(acc_q.size()), 64'd8);
    if (acc_q.size() == 8) check_output("restart_first", 64'(acc_q[0]), 64'(mem0[0]));

    $display("[TB] async reset mid-stream");
    acc_q.delete();
    apply_stimulus(11'd20, 11'd20);
    wait_words(6, 200);
    #2 rst = 1'b1;
    #1;
    check_output("arst_m_vld", 64'(m_vld), 64'd0);
    check_output("arst_rd_en", 64'(rd_en), 64'd0);
    check_output("arst_rd_addr", 64'(rd_addr), 64'd0);
    check_output("arst_busy", 64'(busy), 64'd0);
    check_output("arst_m_last", 64'(m_last), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1 check_output("arst_release_m_vld", 64'(m_vld), 64'd0);
    acc_q.delete();
    apply_stimulus(11'd4, 11'd4);
    wait_idle(200);
    check_output("arst_recover_words", 64'(acc_q.size()), 64'd8);

    $display("[TB] randomized readbacks");
    for (int r = 0; r < 8; r++) begin
      rdy_pct = $urandom_range(100, 40);
      acc_q.delete();
      apply_stimulus(11'($urandom_range(40)), 11'($urandom_range(40)));
      repeat ($urandom_range(8, 2)) @(posedge clk);
      #1 start_read = 1'b1;
      @(posedge clk);
      #1 start_read = 1'b0;
      wait_idle(3000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/capture_reader.md
# capture_reader

Read-side counterpart of the capture path: once a measurement finishes, it reads the captured sample buffers of both channels back out of dual-port BRAM and streams them to firmware over a valid/ready interface. Samples are interleaved as ch0[i], ch1[i]. The block sits between the capture buffer read ports and the firmware data mover. It is gated by the system controller's finish indication, so buffers are never read while they are being written.

## Interface
- FIFO_SIZE, 1024: buffer depth per channel, in samples.
- FIFO_SIZE_WIDTH, $clog2(FIFO_SIZE)+1: count width; address width is FIFO_SIZE_WIDTH-1.
- DATA_WIDTH, 32: sample width.
- RD_LATENCY, 2: BRAM read latency in cycles; legal range 1..3.
- clk  in  1  single clock; everything is synchronous to its rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state.
- finish_op  in  1  capture complete; buffers are stable and readable.
- data_count_ch0, data_count_ch1  in  FIFO_SIZE_WIDTH  captured sample counts.
- start_read  in  1  firmware request to start readback; single-cycle pulse.
- rd_en  out  1  read strobe, shared by both channel BRAMs.
- rd_addr  out  FIFO_SIZE_WIDTH-1  read address, shared by both channels.
- rd_data_ch0, rd_data_ch1  in  DATA_WIDTH  BRAM read data, valid RD_LATENCY cycles after rd_en.
- m_data  out  DATA_WIDTH  stream data.
- m_ch  out  1  channel tag: 0 = ch0, 1 = ch1.
- m_last  out  1  marks the final word of the readback.
- m_vld  out  1  stream valid.
- m_rdy  in  1  stream ready.
- busy  out  1  high in READ and DRAIN.
- read_done  out  1  one-cycle pulse when the final word is accepted.
- event_start_read_when_not_ready  out  1  one-cycle pulse.
- event_count_mismatch  out  1  one-cycle pulse.
- event_finish_lost  out  1  one-cycle pulse.

## Operation
- **States:** IDLE, READ, DRAIN.
- **IDLE:**
  - On start_read & finish_op: latch N = min(data_count_ch0, data_count_ch1), clamped to FIFO_SIZE. If the two counts differ, pulse event_count_mismatch.
  - If N == 0: pulse read_done in the next cycle and stay in IDLE. No m_vld is produced.
  - Otherwise go to READ with rd_addr = 0.
  - start_read & ~finish_op: pulse event_start_read_when_not_ready and stay in IDLE.
- **READ:**
  - Issue rd_en when (reads in flight + pair-FIFO occupancy) < 4.
  - rd_addr increments after each issue.
  - After issuing address N-1, go to DRAIN.
- **DRAIN:** when the last pair has been output and accepted (m_vld & m_rdy & m_last), pulse read_done and go to IDLE.
- **Return path:**
  - A delay line of RD_LATENCY stages carries rd_en as a valid bit.
  - On return, {rd_data_ch1, rd_data_ch0} is pushed into a 4-entry pair FIFO.
  - The output side presents the ch0 word (m_ch = 0), then the ch1 word (m_ch = 1), then pops the pair.
  - m_last = 1 only on the ch1 word of pair N-1.
- **Abort:** if finish_op deasserts in READ or DRAIN:
  - pulse event_finish_lost;
  - flush the pair FIFO and in-flight valids;
  - drop m_vld the next cycle and return to IDLE;
  - read_done is not pulsed.
- start_read while busy is ignored and pulses event_start_read_when_not_ready.
- **Reset values:**
  - all outputs are 0, including rd_addr = 0;
  - state IDLE;
  - FIFO empty and in-flight valids cleared.
- Asserting rst mid-readback discards everything immediately; no m_vld appears in the cycle after release.

## Timing
- start_read is sampled in cycle 0.
- First rd_en is in cycle 1.
- First m_vld is in cycle RD_LATENCY+2.
- **Handshake:**
  - A transfer happens on m_vld & m_rdy.
  - Once asserted, m_vld, m_data, m_ch and m_last hold stable until accepted.
  - m_vld never depends combinationally on m_rdy.
- Sustained throughput with m_rdy held high is one word per cycle; 2N words take about 2N + RD_LATENCY + 2 cycles.
- The credit rule guarantees that no returned pair is ever dropped under any m_rdy pattern.
- rd_addr wraps only through the N bound; no address ≥ N is ever issued.
- The event outputs and read_done are registered, so each pulse appears the cycle after its cause.

## Structure
- A shared package holds:
  - state encodings IDLE = 0, READ = 1, DRAIN = 2;
  - FIFO_SIZE / DATA_WIDTH defaults;
  - the pair-FIFO depth constant (4).
- Sub-module capture_rd_fifo: synchronous FIFO, depth 4, width 2*DATA_WIDTH, with push, pop, flush, empty and count.
- The top level contains the FSM, address counter, credit counter, latency delay line and channel output mux.

## Test plan
- **Basic readback:** counts 8/8, ch0[i] = 0x100+i, ch1[i] = 0x200+i, m_rdy = 1 → 16 words in order 0x100, 0x200, 0x101, … 0x207. m_last only on 0x207; read_done one cycle after it; first m_vld at cycle 4 (RD_LATENCY = 2).
- **Back-pressure:** FIFO_SIZE = 1024 full buffers, random m_rdy at 30% → all 2048 words intact and in order. Outstanding + occupancy never exceeds 4; data is stable during stalls.
- **Count mismatch:** counts 5/3 → event_count_mismatch pulse; exactly 6 words are output; m_last on ch1[2].
- **Zero count and not ready:** counts 0/0 → read_done pulse, m_vld stays 0. start_read with finish_op = 0 → event_start_read_when_not_ready pulse and no rd_en.
- **Abort:** drop finish_op after 10 words → event_finish_lost pulse; m_vld low the next cycle; busy = 0; no read_done. A following start_read with finish_op = 1 restarts from address 0.
- **Async reset:** assert rst mid-stream for 1 cycle, off-edge → all outputs 0 immediately; no spurious m_vld after release.
